calc_seq_controller: RTL and testbench
======================================

// Module: calc_seq_controller
// PURPOSE
//  Parametrised successor to the 16-bit calculator sequencer. Accepts keypad digits, sign toggle and
//  operator/equal strobes, and builds two sign-magnitude operands with internal x10 shift-add.
//  Hands them to an external arithmetic unit over a start/done handshake and shows the result.
//  New behaviour: digit-count limit, clear-entry/all-clear, result chaining, and an error state on
//  overflow or arithmetic timeout.
// PARAMETERS
//  WIDTH          16   operand/result width; bit WIDTH-1 = sign, bits WIDTH-2:0 = magnitude
//  MAX_DIGITS     4    max decimal digits per operand; requires 10**MAX_DIGITS-1 < 2**(WIDTH-1)
//  TIMEOUT_CYCLES 64   cycles to wait for op_done before entering ERROR (>=2)
// PORTS
//  clk             in   1      clock, all logic on posedge
//  RST             in   1      reset; synchronous, active-high
//  keypad_input    in   4      digit value, sampled when read_input=1; values >9 ignored
//  read_input      in   1      1-cycle digit strobe
//  operator_input  in   3      0 none, 1 negate, 2 add, 3 sub, 4 mul, 5 clear entry (CE), 6 all clear (AC), 7 reserved/ignored
//  equal_input     in   1      1-cycle equals strobe
//  key_read        out  1      1-cycle acknowledge of any accepted or ignored strobe
//  op_a, op_b      out  WIDTH  operands to arithmetic unit; held stable from op_start until op_done
//  op_sel          out  2      0 add, 1 sub, 2 mul; held with operands
//  op_start        out  1      1-cycle start pulse
//  op_done         in   1      1-cycle completion from arithmetic unit
//  op_result       in   WIDTH  sign-magnitude result, valid with op_done
//  op_overflow     in   1      result overflow flag, valid with op_done
//  busy            out  1      1 in COMP_START/COMP_WAIT
//  complete        out  1      1 while in RESULT
//  error           out  1      1 while in ERROR
//  display_output  out  WIDTH  operand being entered, or result; 0 in ERROR
// BEHAVIOUR
//  Reset: state ENTER_A; operands, digit counts, latched op, display_output, op_a/op_b/op_sel = 0;
//   key_read, op_start, busy, complete, error = 0. A late op_done after reset is ignored.
//  Strobe priority within a cycle: AC > CE > equal > operator(2-4) > negate > read_input; only the
//   highest-priority strobe acts, but key_read pulses once.
//  Digit (ENTER_A/ENTER_B): if count<MAX_DIGITS, mag <= mag*10 + key ((mag<<3)+(mag<<1)+key), count++.
//   Beyond limit or key>9: no change. Update and key_read both visible the cycle after the strobe.
//  Negate: toggles the current operand's sign bit. 0 with sign set is allowed and displayed as is.
//  CE: clears the current operand (value and count). AC: all operands, latched op and flags cleared;
//   go to ENTER_A from any state, including COMP_WAIT (pending op_done ignored) and ERROR.
//  States / transitions:
//   ENTER_A:    op2-4 -> latch op, ENTER_B (B=0). Equal ignored.
//   ENTER_B:    op2-4 with B count=0 -> replace latched op.
//               op2-4 with B count>0 -> compute, then chain with new op.
//               Equal with B count>0 -> COMP_START; equal with count=0 ignored.
//   COMP_START: drive op_a=A, op_b=B, op_sel; op_start=1 for exactly this cycle -> COMP_WAIT.
//   COMP_WAIT:  on op_done: op_overflow -> ERROR; otherwise capture result -> RESULT (or ENTER_B if chained,
//               A<=result, B cleared, op latched). Timer reaching TIMEOUT_CYCLES without done -> ERROR.
//               All strobes except AC are acknowledged and ignored while busy.
//   RESULT:     display=result, complete=1. op2-4 -> A<=result, ENTER_B.
//               Digit -> fresh A starting with that digit, ENTER_A. Equal/negate ignored.
//   ERROR:      only AC leaves.
//  Latency: equal at cycle N -> op_start at N+1; op_done at M -> display_output/complete at M+1.
// TESTING
//  Digits 1,2, op 2, digits 3,4, equal, unit returns 46 -> op_a=12, op_b=34, op_sel=0, display 46, complete.
//  Digits 5, negate, op 4, digit 3, equal -> op_a=0x8005, op_b=3, op_sel=2; one op_start pulse.
//  Digits 1,2,3,4,5 -> display 1234; key_read 5 pulses; 5th digit dropped.
//  7 + 2, then op 3 (chain); unit returns 9 -> A=9, ENTER_B, op_sel=1; then 4 = -> op_a=9, op_b=4.
//  Withhold op_done for TIMEOUT_CYCLES -> error=1, display 0; AC -> ENTER_A, error=0.
//  op_overflow=1 -> ERROR. AC during COMP_WAIT, then late op_done -> stays ENTER_A.
//  RST mid-entry clears all outputs next cycle.

Source files
------------

// File: rtl/calc_seq_controller_if.sv
// Operand/result handshake between the calculator sequencer and an external arithmetic unit.
// The sequencer is the master: it drives operands and op_start, and the unit answers with op_done.
interface calc_seq_controller_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic             op_start;
  logic             op_done;
  logic [WIDTH-1:0] op_result;
  logic             op_overflow;

  modport master (
    output op_a, op_b, op_sel, op_start,
    input  op_done, op_result, op_overflow
  );

  modport slave (
    input  op_a, op_b, op_sel, op_start,
    output op_done, op_result, op_overflow
  );
endinterface

// File: rtl/calc_seq_controller.sv
// Calculator sequencer: builds two sign-magnitude operands from keypad strobes, runs them
// through an external arithmetic unit, and shows the result, with chaining and error recovery.
module calc_seq_controller #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [3:0]            keypad_input,
  input  logic                  read_input,
  input  logic [2:0]            operator_input,
  input  logic                  equal_input,
  output logic                  key_read,
  output logic                  busy,
  output logic                  complete,
  output logic                  error,
  output logic [WIDTH-1:0]      display_output,
  calc_seq_controller_if.master arith
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] MaxCnt      = CntW'(MAX_DIGITS);
  localparam logic [TmrW-1:0] TimeoutLast = TmrW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StEnterA, StEnterB, StCompStart, StCompWait, StResult, StError
  } state_e;

  typedef enum logic [2:0] {
    CmdNone, CmdAc, CmdCe, CmdEq, CmdOp, CmdNeg, CmdDig
  } cmd_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CntW-1:0]  cnt_a_q, cnt_b_q;
  logic [1:0]       op_q, pend_op_q;
  logic             chain_q;
  logic [TmrW-1:0]  timer_q;

  cmd_e             cmd;
  logic             strobe, key_ok, is_b, digit_ok;
  logic [1:0]       new_sel;
  logic [WIDTH-1:0] cur;
  logic [CntW-1:0]  cur_cnt;
  logic [WIDTH-2:0] key_ext, appended;
  logic             entry_wr;
  logic [WIDTH-1:0] entry_val;
  logic [CntW-1:0]  entry_cnt;

  // Only the highest-priority strobe of the cycle acts.
  always_comb begin
    cmd = CmdNone;
    if (operator_input == 3'd6)      cmd = CmdAc;
    else if (operator_input == 3'd5) cmd = CmdCe;
    else if (equal_input)            cmd = CmdEq;
    else if (operator_input == 3'd2 || operator_input == 3'd3 ||
             operator_input == 3'd4) cmd = CmdOp;
    else if (operator_input == 3'd1) cmd = CmdNeg;
    else if (read_input)             cmd = CmdDig;
  end

  always_comb begin
    strobe   = read_input | equal_input | (operator_input != 3'd0);
    key_ok   = keypad_input <= 4'd9;
    new_sel  = operator_input[1:0] - 2'd2;
    is_b     = (state_q == StEnterB);
    cur      = is_b ? b_q : a_q;
    cur_cnt  = is_b ? cnt_b_q : cnt_a_q;
    digit_ok = key_ok && (cur_cnt < MaxCnt);
    key_ext  = {{(WIDTH-5){1'b0}}, keypad_input};
    appended = (cur[WIDTH-2:0] << 3) + (cur[WIDTH-2:0] << 1) + key_ext;

    entry_wr  = 1'b0;
    entry_val = cur;
    entry_cnt = cur_cnt;
    case (cmd)
      CmdCe: begin
        entry_wr  = 1'b1;
        entry_val = '0;
        entry_cnt = '0;
      end
      CmdNeg: begin
        entry_wr  = 1'b1;
        entry_val = {~cur[WIDTH-1], cur[WIDTH-2:0]};
      end
      CmdDig: begin
        entry_wr  = digit_ok;
        entry_val = {cur[WIDTH-1], appended};
        entry_cnt = cur_cnt + CntW'(1);
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == StCompStart) || (state_q == StCompWait);
  assign complete = (state_q == StResult);
  assign error    = (state_q == StError);

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q        <= StEnterA;
      a_q            <= '0;
      b_q            <= '0;
      cnt_a_q        <= '0;
      cnt_b_q        <= '0;
      op_q           <= '0;
      pend_op_q      <= '0;
      chain_q        <= 1'b0;
      timer_q        <= '0;
      key_read       <= 1'b0;
      display_output <= '0;
      arith.op_a     <= '0;
      arith.op_b     <= '0;
      arith.op_sel   <= '0;
      arith.op_start <= 1'b0;
    end else begin
      key_read       <= strobe;
      arith.op_start <= 1'b0;
      if (cmd == CmdAc) begin
        state_q        <= StEnterA;
        a_q            <= '0;
        b_q            <= '0;
        cnt_a_q        <= '0;
        cnt_b_q        <= '0;
        op_q           <= '0;
        chain_q        <= 1'b0;
        display_output <= '0;
      end else begin
        unique case (state_q)
          StEnterA, StEnterB: begin
            if (entry_wr) begin
              if (is_b) begin
                b_q     <= entry_val;
                cnt_b_q <= entry_cnt;
              end else begin
                a_q     <= entry_val;
                cnt_a_q <= entry_cnt;
              end
              display_output <= entry_val;
            end
            // Launch on equal, or on an operator once B has digits (chained evaluation).
            if ((cmd == CmdEq && is_b && cnt_b_q != '0) ||
                (cmd == CmdOp && is_b && cnt_b_q != '0)) begin
              chain_q        <= (cmd == CmdOp);
              pend_op_q      <= new_sel;
              arith.op_a     <= a_q;
              arith.op_b     <= b_q;
              arith.op_sel   <= op_q;
              arith.op_start <= 1'b1;
              timer_q        <= '0;
              state_q        <= StCompStart;
            end else if (cmd == CmdOp) begin
              op_q <= new_sel;
              if (!is_b) begin
                b_q            <= '0;
                cnt_b_q        <= '0;
                display_output <= '0;
                state_q        <= StEnterB;
              end
            end
          end
          StCompStart: state_q <= StCompWait;
          StCompWait: begin
            if (arith.op_done) begin
              if (arith.op_overflow) begin
                display_output <= '0;
                state_q        <= StError;
              end else begin
                // The result becomes operand A; further digits must not extend it.
                a_q     <= arith.op_result;
                cnt_a_q <= MaxCnt;
                if (chain_q) begin
                  b_q            <= '0;
                  cnt_b_q        <= '0;
                  op_q           <= pend_op_q;
                  chain_q        <= 1'b0;
                  display_output <= '0;
                  state_q        <= StEnterB;
                end else begin
                  display_output <= arith.op_result;
                  state_q        <= StResult;
                end
              end
            end else if (timer_q == TimeoutLast) begin
              display_output <= '0;
              state_q        <= StError;
            end else begin
              timer_q <= timer_q + TmrW'(1);
            end
          end
          StResult: begin
            if (cmd == CmdOp) begin
              op_q           <= new_sel;
              b_q            <= '0;
              cnt_b_q        <= '0;
              display_output <= '0;
              state_q        <= StEnterB;
            end else if (cmd == CmdDig && key_ok) begin
              a_q            <= {1'b0, key_ext};
              cnt_a_q        <= CntW'(1);
              b_q            <= '0;
              cnt_b_q        <= '0;
              display_output <= {1'b0, key_ext};
              state_q        <= StEnterA;
            end
          end
          StError: ;
          default: state_q <= StEnterA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_seq_controller.sv
// Directed bench for calc_seq_controller: entry, operations, chaining, limits, timeout and errors.
// The arithmetic unit is played by the bench with hand-computed results.
module tb_calc_seq_controller;
  localparam int unsigned W = 16;
  localparam int unsigned TO = 64;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   keypad_input = '0;
  logic         read_input = 1'b0;
  logic [2:0]   operator_input = '0;
  logic         equal_input = 1'b0;
  logic         key_read, busy, complete, error;
  logic [W-1:0] display_output;

  int total = 0;
  int bad = 0;

  calc_seq_controller_if #(.WIDTH(W)) arith_if ();

  calc_seq_controller #(.WIDTH(W), .MAX_DIGITS(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .RST            (RST),
    .keypad_input   (keypad_input),
    .read_input     (read_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .key_read       (key_read),
    .busy           (busy),
    .complete       (complete),
    .error          (error),
    .display_output (display_output),
    .arith          (arith_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    keypad_input = d;
    read_input = 1'b1;
    tick();
    read_input = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] o);
    operator_input = o;
    tick();
    operator_input = 3'd0;
  endtask

  task automatic press_eq();
    equal_input = 1'b1;
    tick();
    equal_input = 1'b0;
  endtask

  task automatic pulse_done(input logic [W-1:0] res, input logic ovf);
    arith_if.op_done = 1'b1;
    arith_if.op_result = res;
    arith_if.op_overflow = ovf;
    tick();
    arith_if.op_done = 1'b0;
    arith_if.op_overflow = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    total++; if (display_output !== 16'h0) begin bad++; $display("FAIL reset_display: got %h want 0000", display_output); end
    total++; if ({key_read, busy, complete, error, arith_if.op_start} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {key_read, busy, complete, error, arith_if.op_start}); end
    total++; if ({arith_if.op_a, arith_if.op_b, arith_if.op_sel} !== 34'h0) begin bad++; $display("FAIL reset_operands: got %h want 0", {arith_if.op_a, arith_if.op_b, arith_if.op_sel}); end
    pulse_done(16'd77, 1'b0);
    total++; if ({complete, display_output} !== 17'h0) begin bad++; $display("FAIL reset_late_done: got %h want 0", {complete, display_output}); end
  endtask

  task automatic test_add();
    press_digit(4'd1);
    total++; if (key_read !== 1'b1 || display_output !== 16'd1) begin bad++; $display("FAIL add_first_digit: got kr=%b disp=%h want kr=1 disp=0001", key_read, display_output); end
    tick();
    total++; if (key_read !== 1'b0) begin bad++; $display("FAIL add_key_read_pulse: got %b want 0", key_read); end
    press_digit(4'd2);
    total++; if (display_output !== 16'd12) begin bad++; $display("FAIL add_disp_a: got %0d want 12", display_output); end
    press_op(3'd2);
    total++; if (display_output !== 16'd0) begin bad++; $display("FAIL add_disp_b_empty: got %0d want 0", display_output); end
    press_digit(4'd3);
    press_digit(4'd4);
    total++; if (display_output !== 16'd34) begin bad++; $display("FAIL add_disp_b: got %0d want 34", display_output); end
    press_eq();
    total++; if (arith_if.op_start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL add_start: got start=%b busy=%b want 1 1", arith_if.op_start, busy); end
    total++; if (arith_if.op_a !== 16'd12 || arith_if.op_b !== 16'd34 || arith_if.op_sel !== 2'd0) begin bad++; $display("FAIL add_operands: got a=%0d b=%0d sel=%0d want 12 34 0", arith_if.op_a, arith_if.op_b, arith_if.op_sel); end
    tick();
    total++; if (arith_if.op_start !== 1'b0) begin bad++; $display("FAIL add_start_drop: got %b want 0", arith_if.op_start); end
    // Strobes while busy are acknowledged but change nothing.
    press_digit(4'd9);
    total++; if (key_read !== 1'b1 || display_output !== 16'd34 || arith_if.op_a !== 16'd12) begin bad++; $display("FAIL add_busy_ignore: got kr=%b disp=%0d a=%0d want 1 34 12", key_read, display_output, arith_if.op_a); end
    pulse_done(16'd46, 1'b0);
    total++; if (display_output !== 16'd46 || complete !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL add_result: got disp=%0d cpl=%b busy=%b want 46 1 0", display_output, complete, busy); end
    press_eq();
    total++; if (display_output !== 16'd46 || complete !== 1'b1) begin bad++; $display("FAIL add_result_eq_ignored: got disp=%0d cpl=%b want 46 1", display_output, complete); end
    press_digit(4'd7);
    total++; if (display_output !== 16'd7 || complete !== 1'b0) begin bad++; $display("FAIL add_fresh_digit: got disp=%0d cpl=%b want 7 0", display_output, complete); end
    press_op(3'd6);
  endtask

  task automatic test_neg_mul();
    int starts;
    press_digit(4'd5);
    press_op(3'd1);
    total++; if (display_output !== 16'h8005) begin bad++; $display("FAIL neg_display: got %h want 8005", display_output); end
    press_op(3'd4);
    press_digit(4'd3);
    press_eq();
    total++; if (arith_if.op_a !== 16'h8005 || arith_if.op_b !== 16'd3 || arith_if.op_sel !== 2'd2) begin bad++; $display("FAIL neg_operands: got a=%h b=%h sel=%0d want 8005 0003 2", arith_if.op_a, arith_if.op_b, arith_if.op_sel); end
    starts = (arith_if.op_start === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (arith_if.op_start === 1'b1) starts++;
    end
    total++; if (starts !== 1) begin bad++; $display("FAIL neg_start_count: got %0d want 1", starts); end
    pulse_done(16'h800F, 1'b0);
    total++; if (display_output !== 16'h800F) begin bad++; $display("FAIL neg_result: got %h want 800f", display_output); end
    press_op(3'd6);
  endtask

  task automatic test_digit_limit();
    int acks = 0;
    for (int i = 1; i <= 5; i++) begin
      press_digit(4'(i));
      if (key_read === 1'b1) acks++;
    end
    total++; if (acks !== 5) begin bad++; $display("FAIL limit_key_read: got %0d want 5", acks); end
    total++; if (display_output !== 16'd1234) begin bad++; $display("FAIL limit_display: got %0d want 1234", display_output); end
    press_op(3'd5);
    total++; if (display_output !== 16'd0) begin bad++; $display("FAIL ce_clear: got %0d want 0", display_output); end
    press_digit(4'd12);
    total++; if (key_read !== 1'b1 || display_output !== 16'd0) begin bad++; $display("FAIL bad_key_ignored: got kr=%b disp=%0d want 1 0", key_read, display_output); end
    press_digit(4'd8);
    total++; if (display_output !== 16'd8) begin bad++; $display("FAIL ce_recount: got %0d want 8", display_output); end
    // AC outranks a simultaneous digit.
    operator_input = 3'd6;
    read_input = 1'b1;
    keypad_input = 4'd3;
    tick();
    operator_input = 3'd0;
    read_input = 1'b0;
    total++; if (display_output !== 16'd0 || key_read !== 1'b1) begin bad++; $display("FAIL ac_priority: got disp=%0d kr=%b want 0 1", display_output, key_read); end
  endtask

  task automatic test_replace_op();
    press_digit(4'd6);
    press_eq();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL eq_in_a_ignored: got busy=%b want 0", busy); end
    press_op(3'd2);
    press_eq();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL eq_empty_b_ignored: got busy=%b want 0", busy); end
    press_op(3'd4);
    press_digit(4'd2);
    press_eq();
    total++; if (arith_if.op_a !== 16'd6 || arith_if.op_b !== 16'd2 || arith_if.op_sel !== 2'd2) begin bad++; $display("FAIL replace_op: got a=%0d b=%0d sel=%0d want 6 2 2", arith_if.op_a, arith_if.op_b, arith_if.op_sel); end
    tick();
    pulse_done(16'd12, 1'b0);
    press_op(3'd6);
  endtask

  task automatic test_chain();
    press_digit(4'd7);
    press_op(3'd2);
    press_digit(4'd2);
    press_op(3'd3);
    total++; if (arith_if.op_start !== 1'b1 || arith_if.op_a !== 16'd7 || arith_if.op_b !== 16'd2 || arith_if.op_sel !== 2'd0) begin bad++; $display("FAIL chain_first: got st=%b a=%0d b=%0d sel=%0d want 1 7 2 0", arith_if.op_start, arith_if.op_a, arith_if.op_b, arith_if.op_sel); end
    tick();
    pulse_done(16'd9, 1'b0);
    total++; if (complete !== 1'b0 || busy !== 1'b0 || display_output !== 16'd0) begin bad++; $display("FAIL chain_enter_b: got cpl=%b busy=%b disp=%0d want 0 0 0", complete, busy, display_output); end
    press_digit(4'd4);
    total++; if (display_output !== 16'd4) begin bad++; $display("FAIL chain_b_digit: got %0d want 4", display_output); end
    press_eq();
    total++; if (arith_if.op_a !== 16'd9 || arith_if.op_b !== 16'd4 || arith_if.op_sel !== 2'd1) begin bad++; $display("FAIL chain_second: got a=%0d b=%0d sel=%0d want 9 4 1", arith_if.op_a, arith_if.op_b, arith_if.op_sel); end
    tick();
    pulse_done(16'd5, 1'b0);
    total++; if (display_output !== 16'd5 || complete !== 1'b1) begin bad++; $display("FAIL chain_result: got disp=%0d cpl=%b want 5 1", display_output, complete); end
    press_op(3'd6);
  endtask

  task automatic test_timeout();
    int n = 0;
    press_digit(4'd1);
    press_op(3'd2);
    press_digit(4'd2);
    press_eq();
    while (error !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++; if (n !== TO + 1) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO + 1); end
    total++; if (error !== 1'b1 || display_output !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_error: got err=%b disp=%0d busy=%b want 1 0 0", error, display_output, busy); end
    press_digit(4'd3);
    press_eq();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL error_sticky: got %b want 1", error); end
    press_op(3'd6);
    total++; if (error !== 1'b0 || display_output !== 16'd0) begin bad++; $display("FAIL error_ac: got err=%b disp=%0d want 0 0", error, display_output); end
  endtask

  task automatic test_overflow();
    press_digit(4'd9);
    press_op(3'd4);
    press_digit(4'd9);
    press_eq();
    tick();
    pulse_done(16'd81, 1'b1);
    total++; if (error !== 1'b1 || complete !== 1'b0 || display_output !== 16'd0) begin bad++; $display("FAIL overflow_error: got err=%b cpl=%b disp=%0d want 1 0 0", error, complete, display_output); end
    press_op(3'd6);
  endtask

  task automatic test_ac_busy();
    press_digit(4'd3);
    press_op(3'd2);
    press_digit(4'd4);
    press_eq();
    tick();
    press_op(3'd6);
    total++; if (busy !== 1'b0 || display_output !== 16'd0) begin bad++; $display("FAIL ac_busy: got busy=%b disp=%0d want 0 0", busy, display_output); end
    pulse_done(16'd99, 1'b0);
    total++; if (complete !== 1'b0 || display_output !== 16'd0) begin bad++; $display("FAIL ac_late_done: got cpl=%b disp=%0d want 0 0", complete, display_output); end
    press_digit(4'd8);
    total++; if (display_output !== 16'd8) begin bad++; $display("FAIL ac_reenter: got %0d want 8", display_output); end
    press_op(3'd6);
  endtask

  task automatic test_rst_mid();
    press_digit(4'd4);
    press_digit(4'd5);
    RST = 1'b1;
    read_input = 1'b1;
    keypad_input = 4'd6;
    tick();
    RST = 1'b0;
    read_input = 1'b0;
    total++; if (display_output !== 16'd0 || key_read !== 1'b0) begin bad++; $display("FAIL rst_mid: got disp=%0d kr=%b want 0 0", display_output, key_read); end
  endtask

  initial begin
    arith_if.op_done = 1'b0;
    arith_if.op_result = '0;
    arith_if.op_overflow = 1'b0;
    test_reset();
    test_add();
    test_neg_mul();
    test_digit_limit();
    test_replace_op();
    test_chain();
    test_timeout();
    test_overflow();
    test_ac_busy();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
